count_display_mux: RTL and testbench
====================================

Name: count_display_mux

Overview:
- Downstream consumer of the 4-bit counter stage's `result` output.
- Captures each new count value and converts it to two BCD digits (00–15).
- Also tracks how many times the count wrapped from 15 to 0, kept as BCD 00–99.
- Time-multiplexes all four digits onto the board's 4-digit seven-segment display; segments and anodes are active-low.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit before the scan advances. Legal range ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge
- count_in  input  4  binary count from the counter stage
- count_valid  input  1  count_in is sampled on any edge where this is high
- blank  input  1  high forces all anodes off
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit enables, active-low; an[0] is the rightmost digit

Behaviour:
- Reset (reset==0 at an edge) clears:
  - value_q=0, prev_q=0, bcd registers=0, wrap_bcd=00
  - refresh_cnt=0, digit_sel=0
  - seg=7'b1111111, dp=1, an=4'b1111
- Capture:
  - On count_valid==1: prev_q<=value_q and value_q<=count_in.
  - count_valid==0: hold.
  - Repeated identical values are legal and cause no effect.
- BCD conversion (registered, 1 cycle after value_q changes):
  - ones = value_q mod 10; tens = 1 if value_q ≥10, else 0.
- Wrap detection:
  - When a capture has prev_q==4'hF and new value_q==4'h0, wrap_bcd increments one cycle later.
  - wrap_bcd is a two-digit BCD counter, 00→99→00 (wraps, no saturation).
  - Non-wrap decreases (e.g. 7→3) do not count.
  - Only the exact 15→0 transition counts.
- Refresh:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and digit_sel advances 0→1→2→3→0.
- Digit mapping (digit_sel → anode driven low):
  - 0 → an[0] shows ones
  - 1 → an[1] shows tens; blanked (an[1] stays 1) when tens==0
  - 2 → an[2] shows wrap ones
  - 3 → an[3] shows wrap tens; never blanked
- dp is low only while digit 2 is active, to separate the wrap field from the count field.
- Outputs seg, dp and an are registered from digit_sel and the BCD registers; each output lags digit_sel by 1 cycle.
- Exactly one anode is low at a time, except when blanked.
- Latency: count_valid at edge N → new value_q at N+1 → BCD at N+2 → visible on seg at N+3 if that digit is selected, otherwise at its next scan slot.
- blank:
  - Registered; an=4'b1111 one cycle after blank rises.
  - Scan and refresh continue underneath, so unblanking resumes at the current digit_sel.
- Simultaneous events:
  - A capture coinciding with a digit advance updates normally; the displayed digit picks up the new BCD per the latency above.
  - A capture coinciding with a wrap increment is handled independently.
- Reset mid-scan: next edge restores all reset values, regardless of count_valid or blank.
- Segment codes, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Decomposition:
- Shared package holds:
  - the 10 segment-code constants and SEG_OFF=7'b1111111
  - ANODE_OFF=4'b1111
  - the digit_sel enumeration (DIG_ONES, DIG_TENS, DIG_WRAP_ONES, DIG_WRAP_TENS)
- One sub-module, seg7_bcd_decode: 4-bit BCD in → 7-bit active-low segments out, purely combinational.
  - Codes 10–15 produce SEG_OFF.

Test Plan (REFRESH_DIV=4):
- Reset then release; hold count_valid=0 → seg=1111111/an=1111 during reset. After release, an cycles 1110, (1111 for blanked tens), 1011, 0111, every 4 cycles. Digits 0, 2, 3 all show 1000000.
- Pulse count_valid with count_in=5 → by N+3 plus scan alignment: ones digit shows 0010010 and tens stays blanked. Then count_in=12 → ones 0100100, tens 1111001 with an=1101.
- Apply 14, 15, 0 on consecutive valid pulses → wrap digits show 00→01 (wrap ones 1111001). Then 7→3 → wrap stays 01.
- Drive 100 consecutive 15→0 pairs from reset → wrap_bcd reaches 99 then returns to 00; never shows 10–15 codes.
- Assert blank mid-scan for 10 cycles → an=1111 from the cycle after assertion. On release, the scan resumes at the current digit_sel with the correct segment code.
- Pull reset low during the digit-2 slot while count_valid=1 with count_in=9 → next edge gives an=1111, seg=1111111, value_q=0, wrap=00. The 9 is not captured.

Source files
------------

// File: rtl/count_display_mux_pkg.sv
// Shared constants for the count display: active-low segment codes,
// anode idle pattern and the digit scan enumeration.
package count_display_mux_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // All digit enables released (active-low)
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Scan position; value equals the anode index it drives
  typedef enum logic [1:0] {
    DIG_ONES      = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_WRAP_ONES = 2'd2,
    DIG_WRAP_TENS = 2'd3
  } digit_sel_e;

  // Active-low one-hot anode pattern for a scan position
  function automatic logic [3:0] anode_for(digit_sel_e sel);
    logic [3:0] a;
    a = ANODE_OFF;
    a[sel] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/count_display_mux_seg7_bcd_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal inputs (10..15) leave every segment dark.
module seg7_bcd_decode
  import count_display_mux_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup from digit value to segment pattern
  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/count_display_mux.sv
// Captures the counter stage's value, shows it as two BCD digits next to a
// two-digit BCD count of 15->0 wraps, scanning all four digits of an
// active-low seven-segment display.
module count_display_mux
  import count_display_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       count_valid,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int              CNT_W        = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [3:0]       value_q, prev_q;
  logic             cap_q;
  logic [3:0]       ones_q;
  logic             tens_q;
  logic [3:0]       wrap_ones_q, wrap_tens_q;
  logic [3:0]       wrap_ones_d, wrap_tens_d;
  logic [CNT_W-1:0] refresh_cnt_q;
  digit_sel_e       digit_sel_q;
  logic [3:0]       digit_bcd;
  logic [6:0]       digit_seg;
  logic             digit_lit;
  logic [6:0]       seg_d, seg_q;
  logic             dp_d, dp_q;
  logic [3:0]       an_d, an_q;

  // Capture the incoming count; remember the previous one for wrap detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= 4'd0;
      prev_q  <= 4'd0;
      cap_q   <= 1'b0;
    end else begin
      cap_q <= count_valid;
      if (count_valid) begin
        prev_q  <= value_q;
        value_q <= count_in;
      end
    end
  end

  // Binary 0..15 to two BCD digits, one cycle behind value_q
  always_ff @(posedge clk) begin
    if (!reset) begin
      ones_q <= 4'd0;
      tens_q <= 1'b0;
    end else begin
      tens_q <= (value_q >= 4'd10);
      ones_q <= (value_q >= 4'd10) ? (value_q - 4'd10) : value_q;
    end
  end

  // Next wrap count: BCD increment 00..99..00 on a just-captured 15->0
  always_comb begin
    wrap_ones_d = wrap_ones_q;
    wrap_tens_d = wrap_tens_q;
    if (cap_q && (prev_q == 4'hF) && (value_q == 4'h0)) begin
      if (wrap_ones_q == 4'd9) begin
        wrap_ones_d = 4'd0;
        wrap_tens_d = (wrap_tens_q == 4'd9) ? 4'd0 : (wrap_tens_q + 4'd1);
      end else begin
        wrap_ones_d = wrap_ones_q + 4'd1;
      end
    end
  end

  // Wrap counter state
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_ones_q <= 4'd0;
      wrap_tens_q <= 4'd0;
    end else begin
      wrap_ones_q <= wrap_ones_d;
      wrap_tens_q <= wrap_tens_d;
    end
  end

  // Refresh divider and digit scan; keeps running while blanked
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= DIG_ONES;
    end else if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= digit_sel_e'(digit_sel_q + 2'd1);
    end else begin
      refresh_cnt_q <= refresh_cnt_q + CNT_W'(1);
    end
  end

  // Select the digit value, anode and decimal point for the current scan slot
  always_comb begin
    digit_bcd = 4'd0;
    digit_lit = 1'b1;
    dp_d      = 1'b1;
    case (digit_sel_q)
      DIG_ONES:      digit_bcd = ones_q;
      DIG_TENS: begin
        digit_bcd = {3'b000, tens_q};
        digit_lit = tens_q;
      end
      DIG_WRAP_ONES: begin
        digit_bcd = wrap_ones_q;
        dp_d      = 1'b0;
      end
      DIG_WRAP_TENS: digit_bcd = wrap_tens_q;
      default:       digit_bcd = 4'd0;
    endcase
    an_d  = digit_lit ? anode_for(digit_sel_q) : ANODE_OFF;
    seg_d = digit_lit ? digit_seg : SEG_OFF;
    if (blank) begin
      an_d = ANODE_OFF;
      dp_d = 1'b1;
    end
  end

  seg7_bcd_decode u_decode (
    .bcd_i (digit_bcd),
    .seg_o (digit_seg)
  );

  // Registered display outputs, one cycle behind the scan position
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      an_q  <= ANODE_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_count_display_mux.sv
// Scoreboard bench for count_display_mux with a short refresh divider.
// Stimulus pushes expected display samples tagged with the cycle they are due;
// a negedge monitor pops and compares them.
module tb_count_display_mux;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       count_valid = 1'b0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  count_display_mux #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .blank       (blank),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         chk_seg;
    bit         chk_dp;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc_r  = 0;

  localparam logic [6:0] OFF = 7'b1111111;

  function automatic logic [6:0] code(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return OFF;
    endcase
  endfunction

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.at < cyc) begin
        errors++;
        $display("FAIL %s: sample cycle %0d already passed at cycle %0d", cur.name, cur.at, cyc);
      end else if ((an !== cur.an) || (cur.chk_seg && seg !== cur.seg) ||
                   (cur.chk_dp && dp !== cur.dp)) begin
        errors++;
        $display("FAIL %s @%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 cur.name, cyc, an, seg, dp, cur.an, cur.seg, cur.dp);
      end
    end
  end

  task automatic expect_at(int at, string name, logic [3:0] a, logic [6:0] s,
                           logic d, bit cs, bit cd);
    exp_t e;
    e.at = at; e.name = name; e.an = a; e.seg = s; e.dp = d;
    e.chk_seg = cs; e.chk_dp = cd;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One scan frame (16 cycles) starting at frame index f after reset release
  task automatic push_frame(int f, string tag, logic [6:0] ones_s, bit tens_lit,
                            logic [6:0] tens_s, logic [6:0] wo_s, logic [6:0] wt_s);
    int base;
    base = cyc_r + 16 * f;
    expect_at(base + 1, {tag, " ones"}, 4'b1110, ones_s, 1'b1, 1'b1, 1'b1);
    if (tens_lit)
      expect_at(base + 5, {tag, " tens"}, 4'b1101, tens_s, 1'b1, 1'b1, 1'b1);
    else
      expect_at(base + 5, {tag, " tens blanked"}, 4'b1111, OFF, 1'b1, 1'b0, 1'b1);
    expect_at(base + 9,  {tag, " wrap ones"}, 4'b1011, wo_s, 1'b0, 1'b1, 1'b1);
    expect_at(base + 13, {tag, " wrap tens"}, 4'b0111, wt_s, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic send(logic [3:0] v);
    count_in    = v;
    count_valid = 1'b1;
    @(negedge clk);
  endtask

  // Stop driving, then check the first full frame the new values can reach
  task automatic check_next(string tag, logic [6:0] ones_s, bit tens_lit,
                            logic [6:0] tens_s, logic [6:0] wo_s, logic [6:0] wt_s);
    int f;
    count_valid = 1'b0;
    f = (cyc + 3 - cyc_r + 15) / 16;
    push_frame(f, tag, ones_s, tens_lit, tens_s, wo_s, wt_s);
    wait_cyc(cyc_r + 16 * f + 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c0, c1;
    @(negedge clk);
    // Held in reset: dark display
    c = cyc;
    expect_at(c + 1, "reset a", 4'b1111, OFF, 1'b1, 1'b1, 1'b1);
    expect_at(c + 2, "reset b", 4'b1111, OFF, 1'b1, 1'b1, 1'b1);
    wait_cyc(c + 2);
    reset = 1'b1;
    cyc_r = c + 3;
    push_frame(0, "idle", code(0), 1'b0, OFF, code(0), code(0));
    wait_cyc(cyc_r + 16);

    send(4'd5);
    check_next("v5", code(5), 1'b0, OFF, code(0), code(0));

    send(4'd12);
    check_next("v12", code(2), 1'b1, code(1), code(0), code(0));

    send(4'd14); send(4'd15); send(4'd0);
    check_next("wrap1", code(0), 1'b0, OFF, code(1), code(0));

    send(4'd7); send(4'd3);
    check_next("drop 7-3", code(3), 1'b0, OFF, code(1), code(0));

    send(4'd0); send(4'd0);
    check_next("3-0 repeat", code(0), 1'b0, OFF, code(1), code(0));

    for (int i = 0; i < 98; i++) begin
      send(4'd15); send(4'd0);
    end
    check_next("wrap99", code(0), 1'b0, OFF, code(9), code(9));

    send(4'd15); send(4'd0);
    check_next("wrap00", code(0), 1'b0, OFF, code(0), code(0));

    send(4'd9);
    check_next("v9", code(9), 1'b0, OFF, code(0), code(0));

    // Blank for 10 cycles starting mid digit-0 slot
    c0 = cyc + 2;
    expect_at(c0 + 1,  "blank first",  4'b1111, OFF, 1'b1, 1'b0, 1'b0);
    expect_at(c0 + 5,  "blank mid",    4'b1111, OFF, 1'b1, 1'b0, 1'b0);
    expect_at(c0 + 10, "blank last",   4'b1111, OFF, 1'b1, 1'b0, 1'b0);
    expect_at(c0 + 11, "unblank tens3", 4'b0111, code(0), 1'b1, 1'b1, 1'b1);
    expect_at(c0 + 13, "unblank tens3b", 4'b0111, code(0), 1'b1, 1'b1, 1'b1);
    expect_at(c0 + 14, "unblank ones", 4'b1110, code(9), 1'b1, 1'b1, 1'b1);
    wait_cyc(c0);
    blank = 1'b1;
    wait_cyc(c0 + 10);
    blank = 1'b0;
    wait_cyc(c0 + 16);

    send(4'd15); send(4'd0); send(4'd7);
    check_next("pre-reset", code(7), 1'b0, OFF, code(1), code(0));

    // Reset during the digit-2 slot while a 9 is offered
    c1 = cyc + 9;
    expect_at(c1 + 1, "midreset a", 4'b1111, OFF, 1'b1, 1'b1, 1'b1);
    expect_at(c1 + 2, "midreset b", 4'b1111, OFF, 1'b1, 1'b1, 1'b1);
    wait_cyc(c1);
    reset       = 1'b0;
    count_in    = 4'd9;
    count_valid = 1'b1;
    cyc_r       = c1 + 4;
    push_frame(0, "after reset", code(0), 1'b0, OFF, code(0), code(0));
    wait_cyc(c1 + 3);
    reset       = 1'b1;
    count_valid = 1'b0;
    wait_cyc(cyc_r + 17);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
